pattern_tx: RTL and testbench

Serial pattern transmitter that drives the bit stream consumed by the team's serial sequence detectors, such as the 1011 Mealy detector. A parallel pattern word and a repeat count are captured on a start request. The word is then shifted out MSB first, one bit per clock, for the requested number of repetitions, followed by a single-cycle done pulse. It sits upstream of a detector, on the same clock, in the lab test harnesses and in the board-level demo path.

---
 rtl/pattern_tx.sv | 117 +++++++++++
 tb/tb_pattern_tx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter, MSB first, repeated reps times, then a done pulse.
// Define PT_GAP_EN to insert a one-cycle idle gap between repetitions.
module pattern_tx #(
    parameter int WIDTH = 4,
    parameter int REPW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [REPW-1:0]  reps,
    output logic             X,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
`ifdef PT_GAP_EN
        GAP  = 2'd3,
`endif
        DONE = 2'd2
    } state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] pat_reg, shreg, shreg_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [REPW-1:0] rep_left, rep_left_nxt;
    logic x_nxt, valid_nxt, busy_nxt, done_nxt;
    logic more;
    assign more = rep_left > REPW'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pat_reg  <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            rep_left <= '0;
            X        <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (state == IDLE && start) pat_reg <= data;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            rep_left <= rep_left_nxt;
            X        <= x_nxt;
            valid    <= valid_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = start ? SEND : IDLE;
`ifdef PT_GAP_EN
            SEND: state_nxt = (bit_cnt != '0) ? SEND : (more ? GAP : DONE);
            GAP:  state_nxt = SEND;
`else
            SEND: state_nxt = (bit_cnt != '0 || more) ? SEND : DONE;
`endif
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        rep_left_nxt = rep_left;
        x_nxt        = 1'b0;
        valid_nxt    = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            IDLE: if (start) begin
                shreg_nxt    = data;
                bit_cnt_nxt  = LAST;
                rep_left_nxt = (reps == '0) ? REPW'(1) : reps;
                x_nxt        = data[WIDTH-1];
                valid_nxt    = 1'b1;
                busy_nxt     = 1'b1;
            end
            SEND: if (bit_cnt != '0) begin
                shreg_nxt   = shreg << 1;
                bit_cnt_nxt = bit_cnt - CW'(1);
                x_nxt       = shreg[WIDTH-2];
                valid_nxt   = 1'b1;
                busy_nxt    = 1'b1;
            end else if (more) begin
                rep_left_nxt = rep_left - REPW'(1);
                busy_nxt     = 1'b1;
`ifndef PT_GAP_EN
                shreg_nxt    = pat_reg;
                bit_cnt_nxt  = LAST;
                x_nxt        = pat_reg[WIDTH-1];
                valid_nxt    = 1'b1;
`endif
            end else begin
                done_nxt = 1'b1;
            end
`ifdef PT_GAP_EN
            GAP: begin
                shreg_nxt   = pat_reg;
                bit_cnt_nxt = LAST;
                x_nxt       = pat_reg[WIDTH-1];
                valid_nxt   = 1'b1;
                busy_nxt    = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: scoreboard bench; stimulus queues expected bits/done with their cycle, a monitor pops and checks.
module tb_pattern_tx;
    localparam int W = 4;
`ifdef PT_GAP_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    typedef struct {bit d; bit x; int c;} exp_t;
    logic clk = 0, rst = 1, start = 0;
    logic [W-1:0] data = '0;
    logic [3:0] reps = '0;
    logic X, valid, busy, done;
    int cyc = 0, n_chk = 0, n_fail = 0, k;
    exp_t q[$];
    exp_t me;

    pattern_tx #(.WIDTH(W), .REPW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .reps(reps),
        .X(X), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    // Drive one start request and queue its expected bits and done pulse.
    task automatic send(input logic [W-1:0] d, input logic [3:0] r, output int kk);
        int rr;
        rr = (r == 0) ? 1 : int'(r);
        kk = cyc;
        start = 1; data = d; reps = r;
        for (int p = 0; p < rr; p++)
            for (int j = 0; j < W; j++)
                q.push_back('{1'b0, d[W-1-j], kk + 1 + p * (W + G) + j});
        q.push_back('{1'b1, 1'b0, kk + 1 + rr * W + (rr - 1) * G});
        step();
        start = 0; data = ~d; reps = 4'd7;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        #2;
        chk("drain", q.size(), 0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_x"}, X, 0);
        chk({name, "_valid"}, valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
    endtask

    always @(negedge clk) begin
        if (!valid) chk("x_low", X, 0);
        if (valid || done) begin
            if (q.size() == 0) chk("unexpected_out", {valid, done}, 0);
            else begin
                me = q.pop_front();
                chk("kind_done", done, me.d);
                chk("kind_valid", valid, !me.d);
                chk("cycle", cyc, me.c);
                chk("busy", busy, !me.d);
                if (!me.d) chk("bit", X, me.x);
            end
        end
    end

    initial begin
        repeat (2) step();
        chk_idle("reset");
        rst = 0;
        send(4'b1011, 4'd1, k); wait_idle();
        send(4'b1011, 4'd3, k); wait_idle();
        send(4'b1011, 4'd0, k); wait_idle();
        send(4'b0110, 4'd2, k); wait_idle();
        send(4'b1100, 4'd15, k); wait_idle();
        // Starts while busy and during DONE are ignored; the next cycle's start is taken.
        send(4'b1011, 4'd1, k);
        start = 1; data = 4'b0000; reps = 4'd1;
        step();
        start = 0;
        wait_cyc(k + 1 + W);
        chk("done_seen", done, 1);
        start = 1; data = 4'b0000; reps = 4'd1;
        step();
        send(4'b1001, 4'd1, k); wait_idle();
        // Reset mid-transfer aborts with no done; start accepted right after.
        send(4'b1011, 4'd2, k);
        rst = 1;
        step();
        q.delete();
        chk_idle("abort");
        rst = 0;
        send(4'b1101, 4'd2, k); wait_idle();
        // Reset wins over a simultaneous start.
        rst = 1; start = 1; data = 4'b1111; reps = 4'd1;
        step();
        rst = 0; start = 0;
        chk_idle("rst_start");
        repeat (3) step();
        chk_idle("quiet");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
